// File: rtl/ls193.sv
// ls193 -- 4-bit synchronous up/down counter with pin-edge count inputs.
// The count pins are oversampled on clk; parallel load and clear are
// sampled directly and take priority over any detected count edge.
module ls193 (
  input  logic clk,
  input  logic rst_n,
  input  logic _UP,
  input  logic _DOWN,
  input  logic _CLR,
  input  logic _LOAD,
  input  logic _A,
  input  logic _B,
  input  logic _C,
  input  logic _D,
  output logic _QA,
  output logic _QB,
  output logic _QC,
  output logic _QD,
  output logic _CO,
  output logic _BO
);

  logic       up_s1, up_s2, up_s3;
  logic       dn_s1, dn_s2, dn_s3;
  logic       up_edge, dn_edge;
  logic [3:0] q;

  // Synchronize the count pins and keep one cycle of history for edge detect;
  // reset to all ones so an idle-high pin cannot look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_s1 <= 1'b1;
      up_s2 <= 1'b1;
      up_s3 <= 1'b1;
      dn_s1 <= 1'b1;
      dn_s2 <= 1'b1;
      dn_s3 <= 1'b1;
    end else begin
      up_s1 <= _UP;
      up_s2 <= up_s1;
      up_s3 <= up_s2;
      dn_s1 <= _DOWN;
      dn_s2 <= dn_s1;
      dn_s3 <= dn_s2;
    end
  end

  // Rising edge seen at the synchronizer output.
  always_comb begin
    up_edge = up_s2 & ~up_s3;
    dn_edge = dn_s2 & ~dn_s3;
  end

  // Count register: clear beats load beats counting; edges arriving while
  // clear or load is active are dropped, and opposing edges cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (_CLR) begin
      q <= '0;
    end else if (!_LOAD) begin
      q <= {_D, _C, _B, _A};
    end else if (up_edge && !dn_edge) begin
      q <= q + 4'd1;
    end else if (dn_edge && !up_edge) begin
      q <= q - 4'd1;
    end
  end

  // Carry/borrow decoded purely from flops, so they are clean enough to
  // clock the count pins of a following stage.
  always_comb begin
    _CO = ~((q == 4'd15) & ~up_s2);
    _BO = ~((q == 4'd0)  & ~dn_s2);
  end

  assign _QA = q[0];
  assign _QB = q[1];
  assign _QC = q[2];
  assign _QD = q[3];

endmodule

// File: tb/tb_ls193.sv
// Testbench for ls193: directed scenarios plus a randomized run, all checked
// against a timeline model of when each pin rise becomes a count step.
module tb_ls193;

  logic clk;
  logic rst_n;
  logic up_pin, dn_pin, clr, load;
  logic [3:0] din;
  logic qa, qb, qc, qd, co, bo;
  logic [3:0] q_dut;

  int tests = 0;
  int fails = 0;

  ls193 dut (
    .clk   (clk),
    .rst_n (rst_n),
    ._UP   (up_pin),
    ._DOWN (dn_pin),
    ._CLR  (clr),
    ._LOAD (load),
    ._A    (din[0]),
    ._B    (din[1]),
    ._C    (din[2]),
    ._D    (din[3]),
    ._QA   (qa),
    ._QB   (qb),
    ._QC   (qc),
    ._QD   (qd),
    ._CO   (co),
    ._BO   (bo)
  );

  assign q_dut = {qd, qc, qb, qa};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pin levels are logged per clk edge since the last reset.
  // A pin rise logged at edge k becomes a count step at edge k+2; levels
  // before reset release count as high.
  bit         up_log [0:32767];
  bit         dn_log [0:32767];
  int         cyc;
  logic [3:0] m_q;

  function automatic bit past_up(input int i);
    return (i < 0) ? 1'b1 : up_log[i];
  endfunction

  function automatic bit past_dn(input int i);
    return (i < 0) ? 1'b1 : dn_log[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 4'd0;
      cyc <= 0;
    end else begin
      if (clr)
        m_q <= 4'd0;
      else if (!load)
        m_q <= din;
      else if ((past_up(cyc-2) && !past_up(cyc-3)) && !(past_dn(cyc-2) && !past_dn(cyc-3)))
        m_q <= m_q + 4'd1;
      else if ((past_dn(cyc-2) && !past_dn(cyc-3)) && !(past_up(cyc-2) && !past_up(cyc-3)))
        m_q <= m_q - 4'd1;
      up_log[cyc] <= up_pin;
      dn_log[cyc] <= dn_pin;
      cyc <= cyc + 1;
    end
  end

  bit exp_co, exp_bo;

  task automatic test_reset();
    rst_n  = 1'b0;
    up_pin = 1'b1;
    dn_pin = 1'b1;
    clr    = 1'b0;
    load   = 1'b1;
    din    = 4'd0;
    repeat (3) @(negedge clk);
    tests++; if (q_dut !== 4'd0) begin fails++; $display("FAIL reset_q: got %0d expected 0", q_dut); end
    tests++; if (co !== 1'b1) begin fails++; $display("FAIL reset_co: got %b expected 1", co); end
    tests++; if (bo !== 1'b1) begin fails++; $display("FAIL reset_bo: got %b expected 1", bo); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++; if (q_dut !== 4'd0) begin fails++; $display("FAIL reset_hold_q: cycle %0d got %0d expected 0", i, q_dut); end
      tests++; if (co !== 1'b1 || bo !== 1'b1) begin fails++; $display("FAIL reset_hold_cobo: got %b%b expected 11", co, bo); end
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] want;
    for (int p = 0; p < 16; p++) begin
      for (int ph = 0; ph < 8; ph++) begin
        up_pin = (ph >= 4);
        @(negedge clk);
        exp_co = !(m_q == 4'd15 && !past_up(cyc-2));
        tests++; if (q_dut !== m_q) begin fails++; $display("FAIL up_wrap_q: pulse %0d got %0d expected %0d", p, q_dut, m_q); end
        tests++; if (co !== exp_co) begin fails++; $display("FAIL up_wrap_co: pulse %0d q %0d got %b expected %b", p, q_dut, co, exp_co); end
      end
      want = 4'(p + 1);
      tests++; if (q_dut !== want) begin fails++; $display("FAIL up_wrap_step: pulse %0d got %0d expected %0d", p, q_dut, want); end
      if (p == 14) begin
        // Q is 15 now; during the next pulse low phase carry must assert.
        up_pin = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (co !== 1'b0) begin fails++; $display("FAIL up_wrap_co_low: got %b expected 0", co); end
        up_pin = 1'b1;
        // no rise yet seen by this exit: pin only went low->high here, handled by next pulse
      end
    end
  endtask

  task automatic test_down_wrap();
    for (int ph = 0; ph < 8; ph++) begin
      dn_pin = (ph >= 4);
      @(negedge clk);
      exp_bo = !(m_q == 4'd0 && !past_dn(cyc-2));
      tests++; if (q_dut !== m_q) begin fails++; $display("FAIL down_wrap_q: got %0d expected %0d", q_dut, m_q); end
      tests++; if (bo !== exp_bo) begin fails++; $display("FAIL down_wrap_bo: phase %0d got %b expected %b", ph, bo, exp_bo); end
      if (ph == 3) begin
        tests++; if (bo !== 1'b0) begin fails++; $display("FAIL down_wrap_bo_low: got %b expected 0", bo); end
      end
    end
    tests++; if (q_dut !== 4'd15) begin fails++; $display("FAIL down_wrap_final: got %0d expected 15", q_dut); end
  endtask

  task automatic test_load_clear();
    din  = 4'b1010;
    load = 1'b0;
    @(negedge clk);
    load = 1'b1;
    tests++; if (q_dut !== 4'b1010) begin fails++; $display("FAIL load: got %b expected 1010", q_dut); end
    clr  = 1'b1;
    load = 1'b0;
    @(negedge clk);
    clr  = 1'b0;
    load = 1'b1;
    tests++; if (q_dut !== 4'b0000) begin fails++; $display("FAIL clear_priority: got %b expected 0000", q_dut); end
    up_pin = 1'b0;
    repeat (4) @(negedge clk);
    up_pin = 1'b1;
    load   = 1'b0;
    repeat (4) @(negedge clk);
    load = 1'b1;
    tests++; if (q_dut !== 4'b1010) begin fails++; $display("FAIL load_vs_up: got %b expected 1010", q_dut); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (q_dut !== 4'b1010 || q_dut !== m_q) begin fails++; $display("FAIL load_discard: got %b expected 1010 model %b", q_dut, m_q); end
    end
  endtask

  task automatic test_simultaneous();
    din  = 4'b0111;
    load = 1'b0;
    @(negedge clk);
    load   = 1'b1;
    up_pin = 1'b0;
    dn_pin = 1'b0;
    repeat (4) @(negedge clk);
    up_pin = 1'b1;
    dn_pin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++; if (q_dut !== 4'b0111) begin fails++; $display("FAIL simultaneous: cycle %0d got %b expected 0111", i, q_dut); end
    end
  endtask

  task automatic test_reset_mid();
    din  = 4'd5;
    load = 1'b0;
    @(negedge clk);
    load   = 1'b1;
    up_pin = 1'b0;
    repeat (4) @(negedge clk);
    up_pin = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (q_dut !== 4'd0) begin fails++; $display("FAIL reset_mid_immediate: got %0d expected 0", q_dut); end
    tests++; if (co !== 1'b1 || bo !== 1'b1) begin fails++; $display("FAIL reset_mid_cobo: got %b%b expected 11", co, bo); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++; if (q_dut !== 4'd0) begin fails++; $display("FAIL reset_mid_nostep: cycle %0d got %0d expected 0", i, q_dut); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) up_pin = ~up_pin;
      if ($urandom_range(4) == 0) dn_pin = ~dn_pin;
      clr  = ($urandom_range(40) == 0);
      load = !($urandom_range(30) == 0);
      din  = 4'($urandom);
      @(negedge clk);
      exp_co = !(m_q == 4'd15 && !past_up(cyc-2));
      exp_bo = !(m_q == 4'd0  && !past_dn(cyc-2));
      tests++; if (q_dut !== m_q) begin fails++; $display("FAIL random_q: iter %0d got %0d expected %0d", i, q_dut, m_q); end
      tests++; if (co !== exp_co) begin fails++; $display("FAIL random_co: iter %0d got %b expected %b", i, co, exp_co); end
      tests++; if (bo !== exp_bo) begin fails++; $display("FAIL random_bo: iter %0d got %b expected %b", i, bo, exp_bo); end
    end
    clr  = 1'b0;
    load = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clear();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
